// File: rtl/spu_bp_pkg.sv
// spu_bp_pkg: shared types, fixed-point constants and float<->fixed conversions for spu_backprop
package spu_bp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CONV, S_MUL1, S_MUL2, S_PACK, S_DONE} state_t;
  typedef logic signed [31:0] fixpt_t;
  localparam fixpt_t FIX_ONE = 32'sh0001_0000;
  localparam fixpt_t FIX_MAX = 32'sh7FFF_FFFF;
  localparam fixpt_t FIX_MIN = 32'sh8000_0000;
  function automatic logic fp_is_nan(input logic [31:0] f);
    return f[30:23] == 8'hFF && f[22:0] != 23'd0;
  endfunction
  // A 24-bit mantissa shifted left by 8 or more no longer fits 31 magnitude bits
  function automatic logic fp_fix_sat(input logic [31:0] f, input int frac);
    int sh;
    sh = int'(f[30:23]) - 150 + frac;
    return (f[30:23] == 8'hFF && f[22:0] == 23'd0) || (f[30:23] != 8'h00 && f[30:23] != 8'hFF && sh >= 8);
  endfunction
  function automatic fixpt_t fp_to_fix(input logic [31:0] f, input int frac);
    logic [31:0] m;
    logic [31:0] mag;
    int sh;
    m = {8'd0, 1'b1, f[22:0]};
    sh = int'(f[30:23]) - 150 + frac;
    if (f[30:23] == 8'h00 || fp_is_nan(f)) return '0;
    if (f[30:23] == 8'hFF || sh >= 8) return f[31] ? FIX_MIN : FIX_MAX;
    mag = sh >= 0 ? m << sh : (sh <= -24 ? 32'd0 : m >> (-sh));
    return f[31] ? -fixpt_t'(mag) : fixpt_t'(mag);
  endfunction
  function automatic logic [31:0] fix_to_fp(input fixpt_t x, input int frac);
    logic [31:0] mag;
    logic [22:0] man;
    logic [7:0] e;
    int p;
    if (x == 0) return 32'd0;
    mag = x[31] ? -x : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    man = p >= 23 ? 23'(mag >> (p - 23)) : 23'(mag << (23 - p));
    e = 8'(p - frac + 127);
    return {x[31], e, man};
  endfunction
endpackage

// File: rtl/spu_bp_mul.sv
// spu_bp_mul: signed 32x32 multiply, arithmetic shift by FRAC_BITS, saturate to 32 bits
module spu_bp_mul
  import spu_bp_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  fixpt_t i_a,
  input  fixpt_t i_b,
`ifdef SPU_BP_STATUS_EN
  output logic   o_sat,
`endif
  output fixpt_t o_p
);
  logic signed [63:0] w_prod;
  logic signed [63:0] w_sh;
  logic w_hi;
  logic w_lo;
  assign w_prod = 64'(i_a) * 64'(i_b);
  assign w_sh = w_prod >>> FRAC_BITS;
  assign w_hi = w_sh > 64'sh0000_0000_7FFF_FFFF;
  assign w_lo = w_sh < -64'sh0000_0000_8000_0000;
  assign o_p = w_hi ? FIX_MAX : (w_lo ? FIX_MIN : w_sh[31:0]);
`ifdef SPU_BP_STATUS_EN
  assign o_sat = w_hi | w_lo;
`endif
endmodule

// File: rtl/spu_backprop.sv
// spu_backprop: delta_out = delta * y * (1 - y) in fixed point, one shared multiplier, FSM sequenced.
// Optional SPU_BP_STATUS_EN adds a per-result status[2:0] port (clamp, NaN, saturation).
module spu_backprop
  import spu_bp_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y_float,
  input  logic [31:0] delta_float,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef SPU_BP_STATUS_EN
  output logic [2:0]  status,
`endif
  output logic [31:0] dout_float
);
  localparam fixpt_t ONE = fixpt_t'(32'sd1 <<< FRAC_BITS);
  state_t r_state, w_next;
  logic [31:0] r_y_f, r_d_f, r_dout;
  fixpt_t r_y, r_om, r_delta, r_p, r_r;
  fixpt_t w_y_raw, w_y_clamp, w_mul_a, w_mul_b, w_mul_p;
`ifdef SPU_BP_STATUS_EN
  logic w_mul_sat;
  logic [2:0] r_status;
`endif
  assign in_ready = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign dout_float = r_dout;
  assign w_y_raw = fp_to_fix(r_y_f, FRAC_BITS);
  assign w_y_clamp = w_y_raw < 0 ? '0 : (w_y_raw > ONE ? ONE : w_y_raw);
  assign w_mul_a = r_state == S_MUL1 ? r_y : r_p;
  assign w_mul_b = r_state == S_MUL1 ? r_om : r_delta;
  spu_bp_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .i_a(w_mul_a),
    .i_b(w_mul_b),
`ifdef SPU_BP_STATUS_EN
    .o_sat(w_mul_sat),
`endif
    .o_p(w_mul_p)
  );
  always_ff @(posedge Clk)
    if (!Reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = in_valid ? S_CONV : S_IDLE;
      S_CONV: w_next = S_MUL1;
      S_MUL1: w_next = S_MUL2;
      S_MUL2: w_next = S_PACK;
      S_PACK: w_next = S_DONE;
      S_DONE: w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      r_y_f <= '0;
      r_d_f <= '0;
      r_y <= '0;
      r_om <= '0;
      r_delta <= '0;
      r_p <= '0;
      r_r <= '0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_y_f <= y_float;
          r_d_f <= delta_float;
        end
        S_CONV: begin
          r_y <= w_y_clamp;
          r_om <= ONE - w_y_clamp;
          r_delta <= fp_to_fix(r_d_f, FRAC_BITS);
        end
        S_MUL1: r_p <= w_mul_p;
        S_MUL2: r_r <= w_mul_p;
        S_PACK: r_dout <= fix_to_fp(r_r, FRAC_BITS);
        default: ;
      endcase
    end
`ifdef SPU_BP_STATUS_EN
  always_ff @(posedge Clk)
    if (!Reset_n) r_status <= '0;
    else if (r_state == S_IDLE && in_valid) r_status <= '0;
    else if (r_state == S_CONV)
      r_status <= {fp_fix_sat(r_y_f, FRAC_BITS) | fp_fix_sat(r_d_f, FRAC_BITS),
                   fp_is_nan(r_y_f) | fp_is_nan(r_d_f),
                   w_y_raw < 0 || w_y_raw > ONE};
    else if (r_state == S_MUL1 || r_state == S_MUL2) r_status[2] <= r_status[2] | w_mul_sat;
  assign status = r_status;
`endif
endmodule

// File: tb/tb_spu_backprop.sv
// tb_spu_backprop: directed self-checking bench for spu_backprop
module tb_spu_backprop;
  logic Clk = 0;
  logic Reset_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] y_float = '0;
  logic [31:0] delta_float = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [31:0] dout_float;
  int checks = 0;
  int errors = 0;
`ifdef SPU_BP_STATUS_EN
  logic [2:0] status;
`endif
  spu_backprop dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_float(y_float),
    .delta_float(delta_float),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SPU_BP_STATUS_EN
    .status(status),
`endif
    .dout_float(dout_float)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] y, input logic [31:0] d);
    @(negedge Clk);
    in_valid = 1;
    y_float = y;
    delta_float = d;
    @(posedge Clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] y, input logic [31:0] d,
                     input logic [31:0] exp, input logic [2:0] st);
    int n;
    xfer(y, d);
    wait_valid(n);
    check({tag, "_lat"}, 32'(n), 32'd5);
    check({tag, "_dout"}, dout_float, exp);
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
`ifdef SPU_BP_STATUS_EN
    check({tag, "_status"}, {29'd0, status}, {29'd0, st});
`else
    if (st > 3'd7) check({tag, "_st"}, 32'd0, 32'd1);
`endif
    @(negedge Clk);
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask
  initial begin
    int n;
    logic [31:0] held;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_state", {30'd0, in_ready, out_valid}, 32'b10);
    check("rst_dout", dout_float, 32'h0000_0000);
    Reset_n = 1;
    run("half_one", 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 3'b000);
    run("q3_neg2", 32'h3F40_0000, 32'hC000_0000, 32'hBEC0_0000, 3'b000);
    run("clamp_hi", 32'h3FC0_0000, 32'h40A0_0000, 32'h0000_0000, 3'b001);
    run("clamp_neg", 32'hBF00_0000, 32'h3F80_0000, 32'h0000_0000, 3'b001);
    run("nan_delta", 32'h3F00_0000, 32'h7FC0_0000, 32'h0000_0000, 3'b010);
    run("neg_inf", 32'h3F00_0000, 32'hFF80_0000, 32'hC600_0000, 3'b100);
    run("denorm", 32'h3F00_0000, 32'h0000_0001, 32'h0000_0000, 3'b000);
    out_ready = 0;
    xfer(32'h3F40_0000, 32'hC000_0000);
    wait_valid(n);
    check("bp_lat", 32'(n), 32'd5);
    held = dout_float;
    check("bp_dout", held, 32'hBEC0_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("bp_hold", {dout_float[31:2], out_valid, in_ready}, {held[31:2], 2'b10});
    end
    out_ready = 1;
    @(negedge Clk);
    check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    xfer(32'h3F00_0000, 32'h3F80_0000);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 0;
    @(negedge Clk);
    check("midrst_state", {30'd0, in_ready, out_valid}, 32'b10);
    check("midrst_dout", dout_float, 32'h0000_0000);
    Reset_n = 1;
    repeat (8) @(negedge Clk);
    check("midrst_quiet", {31'd0, out_valid}, 32'd0);
    run("after_rst", 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
